// File: rtl/common.sv
// Shared posit definitions: the unpacked field set and the special bit patterns
// for a posit of a given width (results are right-aligned in 16 bits).
package common;

  typedef struct packed {
    logic              sign;
    logic signed [7:0] regime;
    logic signed [7:0] exponent;
    logic        [7:0] mantissa;
    logic              is_zero;
    logic              is_nar;
  } posit_fields_t;

  function automatic logic [15:0] maxpos(input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [15:0] minpos(input int width);
    return (width > 1) ? 16'd1 : 16'd0;
  endfunction

  function automatic logic [15:0] nar(input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == width - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/posit_regime_encoder.sv
// Turns regime value k into a left-aligned regime bit pattern and its run length
// (run plus terminating bit). k is clamped to the range where saturation already holds.
module posit_regime_encoder #(
  parameter  int WIDTH = 7,
  localparam int RW    = WIDTH + 1,
  localparam int LENW  = $clog2(WIDTH + 2)
) (
  input  logic signed [7:0]      k,
  output logic        [RW-1:0]   pattern,
  output logic        [LENW-1:0] run_len
);

  localparam logic signed [7:0] K_HI = 8'(WIDTH - 1);
  localparam logic signed [7:0] K_LO = 8'(1 - WIDTH);
  localparam logic [RW-1:0]     ONES = {RW{1'b1}};
  localparam logic [RW-1:0]     TOP  = {1'b1, {(RW-1){1'b0}}};

  logic signed [7:0] k_c;
  logic        [7:0] k_mag;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    pattern = '0;
    run_len = '0;
    if (k > K_HI)      k_c = K_HI;
    else if (k < K_LO) k_c = K_LO;
    else               k_c = k;
    k_mag = k_c[7] ? 8'(-k_c) : k_c;
    if (!k_c[7]) begin
      // k >= 0: k+1 ones then a zero
      pattern = ~(ONES >> (k_mag + 8'd1));
      run_len = LENW'(k_mag + 8'd2);
    end else begin
      // k < 0: -k zeros then a one
      pattern = TOP >> k_mag;
      run_len = LENW'(k_mag + 8'd1);
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Three-stage posit packer: S1 regime, S2 field packing with round/sticky,
// S3 round-to-nearest-even, saturation, sign and exception override.
module posit_encoder
  import common::*;
#(
  parameter int WIDTH = 7,
  parameter int ES    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic signed [7:0]       regime,
  input  logic signed [7:0]       exponent,
  input  logic        [7:0]       mantissa,
  input  logic                    is_zero,
  input  logic                    is_nar,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] q
);

  localparam int RW   = WIDTH + 1;
  localparam int LENW = $clog2(WIDTH + 2);
  localparam int FW   = RW + 16;
  localparam logic [WIDTH-1:0] MAXPOS = WIDTH'(maxpos(WIDTH));
  localparam logic [WIDTH-1:0] MINPOS = WIDTH'(minpos(WIDTH));
  localparam logic [WIDTH-1:0] NAR    = WIDTH'(nar(WIDTH));

  typedef struct packed {
    logic            valid;
    logic            sign;
    logic            is_zero;
    logic            is_nar;
    logic [RW-1:0]   reg_pat;
    logic [LENW-1:0] run_len;
    logic [15:0]     em_al;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic             is_zero;
    logic             is_nar;
    logic [WIDTH-2:0] body;
    logic             rnd;
    logic             sticky;
  } s2_t;

  posit_fields_t    in_f;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] q_d, q_q;
  logic [RW-1:0]    reg_pat;
  logic [LENW-1:0]  run_len;
  logic             en;

  assign in_f = '{sign: sign, regime: regime, exponent: exponent, mantissa: mantissa,
                  is_zero: is_zero, is_nar: is_nar};

  // One enable for every stage: a stalled output freezes the whole pipe.
  assign en        = out_ready | ~out_valid_q;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign q         = q_q;

  posit_regime_encoder #(.WIDTH(WIDTH)) u_regime (
    .k       (in_f.regime),
    .pattern (reg_pat),
    .run_len (run_len)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.valid   = in_valid;
    s1_d.sign    = in_f.sign;
    s1_d.is_zero = in_f.is_zero;
    s1_d.is_nar  = in_f.is_nar;
    s1_d.reg_pat = reg_pat;
    s1_d.run_len = run_len;
    // Low ES exponent bits followed by the fraction, MSB-aligned in 16 bits.
    s1_d.em_al   = 16'({in_f.exponent, in_f.mantissa} << (8 - ES));
  end

  logic [LENW-1:0] shamt;
  logic [FW-1:0]   field;

  always_comb begin
    s2_d         = '0;
    shamt        = LENW'(RW) - s1_q.run_len;
    field        = {s1_q.reg_pat, 16'h0} | ({{RW{1'b0}}, s1_q.em_al} << shamt);
    s2_d.valid   = s1_q.valid;
    s2_d.sign    = s1_q.sign;
    s2_d.is_zero = s1_q.is_zero;
    s2_d.is_nar  = s1_q.is_nar;
    s2_d.body    = field[FW-1 -: WIDTH-1];
    s2_d.rnd     = field[FW-WIDTH];
    s2_d.sticky  = |field[FW-WIDTH-1:0];
  end

  logic             inc;
  logic [WIDTH-2:0] rounded;
  logic [WIDTH-1:0] mag;

  always_comb begin
    // Never round past maxpos, and never let a nonzero value land on zero.
    inc     = s2_q.rnd & (s2_q.sticky | s2_q.body[0]) & ({1'b0, s2_q.body} != MAXPOS);
    rounded = s2_q.body + {{(WIDTH-2){1'b0}}, inc};
    mag     = (rounded == '0) ? MINPOS : {1'b0, rounded};
    q_d     = s2_q.sign ? -mag : mag;
    if (s2_q.is_nar)       q_d = NAR;
    else if (s2_q.is_zero) q_d = '0;
    out_valid_d = s2_q.valid;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous stage's old value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
    end else if (en) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (WIDTH=7, ES=1): values, rounding, saturation,
// exceptions, backpressure and reset with data in flight.
module tb_posit_encoder;
  import common::*;

  localparam int WIDTH = 7;
  localparam int ES    = 1;

  logic              clk, rst_n, in_valid, in_ready, sign, is_zero, is_nar;
  logic              out_valid, out_ready;
  logic signed [7:0] regime, exponent;
  logic        [7:0] mantissa;
  logic [WIDTH-1:0]  q;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stall_left = 0;
  logic chk_lat = 1'b0;
  logic was_stalled = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] val;
    string            tag;
    int               cyc;
  } exp_t;
  exp_t exp_q[$];

  posit_encoder #(.WIDTH(WIDTH), .ES(ES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .regime    (regime),
    .exponent  (exponent),
    .mantissa  (mantissa),
    .is_zero   (is_zero),
    .is_nar    (is_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic posit_fields_t mk(input logic s, input int k, input int e,
                                       input logic [7:0] m, input logic z = 1'b0,
                                       input logic n = 1'b0);
    posit_fields_t f;
    f.sign     = s;
    f.regime   = 8'(k);
    f.exponent = 8'(e);
    f.mantissa = m;
    f.is_zero  = z;
    f.is_nar   = n;
    return f;
  endfunction

  // One clock: drive at the falling edge, sample 1 time unit later.
  task automatic cycle(input logic v, input posit_fields_t f, input logic [WIDTH-1:0] e,
                       input string tag, output logic acc);
    exp_t x;
    @(negedge clk);
    out_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    in_valid = v;
    sign     = f.sign;
    regime   = f.regime;
    exponent = f.exponent;
    mantissa = f.mantissa;
    is_zero  = f.is_zero;
    is_nar   = f.is_nar;
    #1;
    if (was_stalled) check("stall_out_valid", 32'(out_valid), 32'd1);
    if (out_valid && !out_ready) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (exp_q.size() > 0) check({exp_q[0].tag, "_held"}, 32'(q), 32'(exp_q[0].val));
    end
    if (exp_q.size() == 0) begin
      check("no_spurious_out", 32'(out_valid), 32'd0);
    end else if (out_valid && out_ready) begin
      x = exp_q.pop_front();
      check(x.tag, 32'(q), 32'(x.val));
      if (chk_lat) check({x.tag, "_latency"}, 32'(cyc - x.cyc), 32'd3);
    end
    was_stalled = out_valid && !out_ready;
    acc = v && in_ready;
    if (acc) exp_q.push_back('{val: e, tag: tag, cyc: cyc});
  endtask

  task automatic send(input posit_fields_t f, input logic [WIDTH-1:0] e, input string tag);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cycle(1'b1, f, e, tag, acc);
      tries++;
    end
    check({tag, "_accepted"}, 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, "idle", acc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 30) begin
      idle(1);
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; regime = '0; exponent = '0; mantissa = '0; is_zero = 1'b0; is_nar = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back stream, latency checked on every result.
    chk_lat = 1'b1;
    send(mk(0, 0, 0, 8'h00), 7'h20, "b_k0e0");
    send(mk(0, 0, 1, 8'h00), 7'h28, "b_k0e1");
    send(mk(0, 0, 0, 8'h80), 7'h24, "b_k0m80");
    send(mk(0, 1, 0, 8'h00), 7'h30, "b_k1");
    send(mk(1, 0, 0, 8'h00), 7'h60, "b_neg");
    send(mk(0, 0, 0, 8'h10), 7'h20, "r_tie_even");
    send(mk(0, 0, 0, 8'h18), 7'h21, "r_above_tie");
    send(mk(0, 0, 0, 8'hFF), 7'h28, "r_carry_exp");
    send(mk(0, 0, 1, 8'hFF), 7'h30, "r_carry_regime");
    send(mk(0, 4, 1, 8'h00), 7'h3E, "r_k4_tie");
    send(mk(0, 4, 1, 8'h80), 7'h3F, "r_k4_up");
    send(mk(0, 5, 0, 8'h00), 7'h3F, "s_k5");
    send(mk(0, 10, 1, 8'hFF), 7'h3F, "s_k10");
    send(mk(0, -4, 1, 8'h00), 7'h03, "s_km4");
    send(mk(0, -10, 0, 8'h00), 7'h01, "s_km10");
    send(mk(1, 10, 0, 8'h00), 7'h41, "s_neg_k10");
    send(mk(1, -10, 0, 8'h00), 7'h7F, "s_neg_km10");
    send(mk(1, 3, 1, 8'hA5, 1'b0, 1'b1), 7'h40, "x_nar");
    send(mk(0, 2, 1, 8'h55, 1'b1, 1'b0), 7'h00, "x_zero");
    send(mk(0, 1, 0, 8'h33, 1'b1, 1'b1), 7'h40, "x_nar_and_zero");
    drain();

    // Backpressure: 5-cycle stall once the first result is presented.
    chk_lat = 1'b0;
    send(mk(0, 0, 0, 8'h80), 7'h24, "bp_a");
    send(mk(0, 1, 0, 8'h00), 7'h30, "bp_b");
    send(mk(0, -1, 0, 8'h00), 7'h10, "bp_c");
    stall_left = 5;
    send(mk(1, 0, 0, 8'h00), 7'h60, "bp_d");
    drain();

    // Reset with two items in flight, the first already presented.
    stall_left = 10;
    send(mk(0, 0, 0, 8'h00), 7'h20, "rst_x");
    send(mk(0, 0, 1, 8'h00), 7'h28, "rst_y");
    idle(2);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_q", 32'(q), 32'd0);
    exp_q.delete();
    was_stalled = 1'b0;
    stall_left  = 0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst2", 32'(in_ready), 32'd1);
    idle(8);
    send(mk(0, 1, 1, 8'h00), 7'h34, "post_rst_k1e1");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
